// File: rtl/gbt_pattern_checker_if.sv
// Clock/reset bundle for the GBT pattern checker.
// Carries the frame clock and its synchronous active-high reset.
interface gbt_clkrs_if;
  logic clk;
  logic reset;

  modport sink (
    input clk,
    input reset
  );

  modport source (
    output clk,
    output reset
  );
endinterface

// File: rtl/gbt_pattern_checker.sv
// GBT receive test-pattern checker: locks onto a {cnt,cnt} counter stream.
// Ports: ClkRs_ix (clk/reset), link_ready, data_valid, data_b64, clear in;
//   locked, error_pulse, error_count, frame_count, unlock_count,
//   err_rx_word, err_exp_word out.
// Optional first-error capture is enabled by GBT_CHECKER_ERR_CAPTURE_EN.
module gbt_pattern_checker #(
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned MAX_ERRORS = 4
) (
  gbt_clkrs_if.sink    ClkRs_ix,
  input  logic         link_ready,
  input  logic         data_valid,
  input  logic [63:0]  data_b64,
  input  logic         clear,
  output logic         locked,
  output logic         error_pulse,
  output logic [31:0]  error_count,
  output logic [31:0]  frame_count,
  output logic [15:0]  unlock_count,
  output logic [63:0]  err_rx_word,
  output logic [31:0]  err_exp_word
);

  localparam logic [7:0] LOCK_N = 8'(LOCK_COUNT);
  localparam logic [3:0] MAX_N  = 4'(MAX_ERRORS);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_VERIFY,
    S_LOCKED
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] exp_q, exp_d;
  logic [7:0]  good_q, good_d;
  logic [3:0]  bad_q, bad_d;

  logic        locked_q, locked_d;
  logic        pulse_q, pulse_d;
  logic [31:0] err_cnt_q, err_cnt_d;
  logic [31:0] frm_cnt_q, frm_cnt_d;
  logic [15:0] unl_cnt_q, unl_cnt_d;

  logic        half_eq;
  logic        good_frm;
  logic        bad_ev;
  logic        unlock_ev;
  logic        frame_ev;
  logic [7:0]  good_inc;
  logic [3:0]  bad_inc;

  assign half_eq  = (data_b64[63:32] == data_b64[31:0]);
  assign good_frm = half_eq && (data_b64[31:0] == exp_q);
  assign frame_ev = link_ready && data_valid;
  assign good_inc = good_q + 8'd1;
  assign bad_inc  = bad_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    good_d    = good_q;
    bad_d     = bad_q;
    bad_ev    = 1'b0;
    unlock_ev = 1'b0;
    if (!link_ready) begin
      // Link loss drops every state back to search; frames are ignored.
      state_d   = S_SEARCH;
      good_d    = 8'd0;
      bad_d     = 4'd0;
      unlock_ev = (state_q == S_LOCKED);
    end else if (data_valid) begin
      unique case (state_q)
        S_SEARCH: begin
          if (half_eq) begin
            exp_d   = data_b64[31:0] + 32'd1;
            good_d  = 8'd1;
            state_d = S_VERIFY;
          end
        end
        S_VERIFY: begin
          if (good_frm) begin
            exp_d  = exp_q + 32'd1;
            good_d = good_inc;
            if (good_inc == LOCK_N) begin
              state_d = S_LOCKED;
            end
          end else begin
            good_d  = 8'd0;
            state_d = S_SEARCH;
          end
        end
        S_LOCKED: begin
          // No resync while locked: the counter always advances.
          exp_d = exp_q + 32'd1;
          if (good_frm) begin
            bad_d = 4'd0;
          end else begin
            bad_ev = 1'b1;
            bad_d  = bad_inc;
            if (bad_inc == MAX_N) begin
              state_d   = S_SEARCH;
              unlock_ev = 1'b1;
              bad_d     = 4'd0;
              good_d    = 8'd0;
            end
          end
        end
        default: begin
          state_d = S_SEARCH;
          good_d  = 8'd0;
          bad_d   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    locked_d  = (state_d == S_LOCKED);
    pulse_d   = bad_ev;
    err_cnt_d = err_cnt_q;
    frm_cnt_d = frm_cnt_q;
    unl_cnt_d = unl_cnt_q;
    if (clear) begin
      err_cnt_d = 32'd0;
      frm_cnt_d = 32'd0;
      unl_cnt_d = 16'd0;
    end else begin
      if (bad_ev && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + 32'd1;
      end
      if (frame_ev && (frm_cnt_q != '1)) begin
        frm_cnt_d = frm_cnt_q + 32'd1;
      end
      if (unlock_ev && (unl_cnt_q != '1)) begin
        unl_cnt_d = unl_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge ClkRs_ix.clk) begin
    if (ClkRs_ix.reset) begin
      state_q   <= S_SEARCH;
      exp_q     <= 32'd0;
      good_q    <= 8'd0;
      bad_q     <= 4'd0;
      locked_q  <= 1'b0;
      pulse_q   <= 1'b0;
      err_cnt_q <= 32'd0;
      frm_cnt_q <= 32'd0;
      unl_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      locked_q  <= locked_d;
      pulse_q   <= pulse_d;
      err_cnt_q <= err_cnt_d;
      frm_cnt_q <= frm_cnt_d;
      unl_cnt_q <= unl_cnt_d;
    end
  end

`ifdef GBT_CHECKER_ERR_CAPTURE_EN
  logic [63:0] cap_rx_q, cap_rx_d;
  logic [31:0] cap_exp_q, cap_exp_d;
  logic        cap_done_q, cap_done_d;

  // Holds the first locked-state error until reset or clear re-arms it.
  always_comb begin
    cap_rx_d   = cap_rx_q;
    cap_exp_d  = cap_exp_q;
    cap_done_d = cap_done_q;
    if (clear) begin
      cap_rx_d   = 64'd0;
      cap_exp_d  = 32'd0;
      cap_done_d = 1'b0;
    end else if (bad_ev && !cap_done_q) begin
      cap_rx_d   = data_b64;
      cap_exp_d  = exp_q;
      cap_done_d = 1'b1;
    end
  end

  always_ff @(posedge ClkRs_ix.clk) begin
    if (ClkRs_ix.reset) begin
      cap_rx_q   <= 64'd0;
      cap_exp_q  <= 32'd0;
      cap_done_q <= 1'b0;
    end else begin
      cap_rx_q   <= cap_rx_d;
      cap_exp_q  <= cap_exp_d;
      cap_done_q <= cap_done_d;
    end
  end

  assign err_rx_word  = cap_rx_q;
  assign err_exp_word = cap_exp_q;
`else
  assign err_rx_word  = 64'd0;
  assign err_exp_word = 32'd0;
`endif

  assign locked       = locked_q;
  assign error_pulse  = pulse_q;
  assign error_count  = err_cnt_q;
  assign frame_count  = frm_cnt_q;
  assign unlock_count = unl_cnt_q;

endmodule
